// File: rtl/vote_booth_arbiter.sv
// vote_booth_arbiter: round-robin arbiter sharing one ballot counter among NUM_BOOTHS booths.
// Optional VOTE_ARB_STATS_EN adds saturating accepted/rejected counters.
module vote_booth_arbiter #(
    parameter int NUM_BOOTHS     = 4,
    parameter int TIMEOUT        = 8,
    parameter int RELEASE_CYCLES = 2,
    localparam int IW = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1,
    localparam int TW = $clog2(TIMEOUT),
    localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_BOOTHS-1:0]   booth_req,
    input  logic [4*NUM_BOOTHS-1:0] booth_voter_id,
    input  logic [2*NUM_BOOTHS-1:0] booth_choice,
    input  logic                    voting_enabled,
    input  logic                    busy,
    output logic [NUM_BOOTHS-1:0]   booth_ack,
    output logic                    booth_accepted,
    output logic [3:0]              voter_id,
`ifdef VOTE_ARB_STATS_EN
    output logic [7:0]              accepted_count,
    output logic [7:0]              rejected_count,
`endif
    output logic                    vote_a,
    output logic                    vote_b,
    output logic                    vote_c,
    output logic                    grant_valid,
    output logic [IW-1:0]           grant_idx
);
    typedef enum logic [1:0] {IDLE, PRESENT, RELEASE, DONE} state_t;

    state_t                  state_q;
    logic [NUM_BOOTHS-1:0]   ack_q;
    logic                    accepted_q, acc_q, va_q, vb_q, vc_q, gv_q;
    logic [3:0]              voter_id_q;
    logic [IW-1:0]           grant_idx_q, last_q, pick;
    logic [TW-1:0]           to_q;
    logic [RW-1:0]           rel_q;
    logic                    found;
    logic [1:0]              pick_choice;
    logic [3:0]              pick_id;
`ifdef VOTE_ARB_STATS_EN
    logic [7:0]              acc_cnt_q, rej_cnt_q;
`endif

    // Descending scan so the nearest booth after last_q overwrites farther ones.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = NUM_BOOTHS; k >= 1; k--) begin
            if (booth_req[(int'(last_q) + k) % NUM_BOOTHS]) begin
                pick  = IW'((int'(last_q) + k) % NUM_BOOTHS);
                found = 1'b1;
            end
        end
    end

    assign pick_choice = booth_choice[2*pick +: 2];
    assign pick_id     = booth_voter_id[4*pick +: 4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ack_q       <= '0;
            accepted_q  <= 1'b0;
            acc_q       <= 1'b0;
            {va_q, vb_q, vc_q} <= 3'b000;
            gv_q        <= 1'b0;
            voter_id_q  <= '0;
            grant_idx_q <= '0;
            last_q      <= IW'(NUM_BOOTHS - 1);
            to_q        <= '0;
            rel_q       <= '0;
`ifdef VOTE_ARB_STATS_EN
            acc_cnt_q   <= '0;
            rej_cnt_q   <= '0;
`endif
        end else begin
            ack_q      <= '0;
            accepted_q <= 1'b0;
            case (state_q)
                IDLE: if (voting_enabled && found) begin
                    gv_q        <= 1'b1;
                    grant_idx_q <= pick;
                    voter_id_q  <= pick_id;
                    acc_q       <= 1'b0;
                    to_q        <= '0;
                    {va_q, vb_q, vc_q} <= {pick_choice == 2'd1, pick_choice == 2'd2, pick_choice == 2'd3};
                    state_q     <= (pick_choice == 2'd0) ? DONE : PRESENT;
                end
                PRESENT: if (busy || !voting_enabled || to_q == TW'(TIMEOUT - 1)) begin
                    acc_q   <= busy;
                    {va_q, vb_q, vc_q} <= 3'b000;
                    rel_q   <= '0;
                    state_q <= RELEASE;
                end else begin
                    to_q <= to_q + 1'b1;
                end
                RELEASE: if (rel_q == RW'(RELEASE_CYCLES - 1)) begin
                    ack_q      <= NUM_BOOTHS'(1) << grant_idx_q;
                    accepted_q <= acc_q;
                    state_q    <= DONE;
                end else begin
                    rel_q <= rel_q + 1'b1;
                end
                default: if (ack_q == '0) begin
                    // Invalid-choice path arrives here without an ack yet; emit it now.
                    ack_q      <= NUM_BOOTHS'(1) << grant_idx_q;
                    accepted_q <= acc_q;
                end else begin
                    gv_q       <= 1'b0;
                    voter_id_q <= '0;
                    last_q     <= grant_idx_q;
                    state_q    <= IDLE;
`ifdef VOTE_ARB_STATS_EN
                    if (accepted_q && acc_cnt_q != 8'hff) acc_cnt_q <= acc_cnt_q + 1'b1;
                    if (!accepted_q && rej_cnt_q != 8'hff) rej_cnt_q <= rej_cnt_q + 1'b1;
`endif
                end
            endcase
        end
    end

    assign booth_ack      = ack_q;
    assign booth_accepted = accepted_q;
    assign voter_id       = voter_id_q;
    assign vote_a         = va_q;
    assign vote_b         = vb_q;
    assign vote_c         = vc_q;
    assign grant_valid    = gv_q;
    assign grant_idx      = grant_idx_q;
`ifdef VOTE_ARB_STATS_EN
    assign accepted_count = acc_cnt_q;
    assign rejected_count = rej_cnt_q;
`endif
endmodule

// File: tb/tb_vote_booth_arbiter.sv
// tb_vote_booth_arbiter: scoreboard bench with a behavioural ballot counter model.
module tb_vote_booth_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0, reset = 1'b1;
    logic [N-1:0]   booth_req = '0;
    logic [4*N-1:0] booth_voter_id = '0;
    logic [2*N-1:0] booth_choice = '0;
    logic           voting_enabled = 1'b1;
    logic           busy;
    logic [N-1:0]   booth_ack;
    logic           booth_accepted, vote_a, vote_b, vote_c, grant_valid;
    logic [3:0]     voter_id;
    logic [1:0]     grant_idx;
`ifdef VOTE_ARB_STATS_EN
    logic [7:0]     accepted_count, rejected_count;
`endif

    vote_booth_arbiter #(.NUM_BOOTHS(N), .TIMEOUT(8), .RELEASE_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .booth_req(booth_req), .booth_voter_id(booth_voter_id),
        .booth_choice(booth_choice), .voting_enabled(voting_enabled), .busy(busy),
        .booth_ack(booth_ack), .booth_accepted(booth_accepted), .voter_id(voter_id),
`ifdef VOTE_ARB_STATS_EN
        .accepted_count(accepted_count), .rejected_count(rejected_count),
`endif
        .vote_a(vote_a), .vote_b(vote_b), .vote_c(vote_c),
        .grant_valid(grant_valid), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Counter model: busy rises two cycles after a fresh voter's line goes high, holds until release.
    logic [15:0] used;
    logic [1:0]  dly;
    int          cnt_a, cnt_b, cnt_c;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0; used <= '0; dly <= '0;
            cnt_a <= 0; cnt_b <= 0; cnt_c <= 0;
        end else if (vote_a || vote_b || vote_c) begin
            if (!busy && !used[voter_id]) begin
                if (dly == 2'd1) begin
                    busy <= 1'b1;
                    used[voter_id] <= 1'b1;
                    if (vote_a) cnt_a <= cnt_a + 1;
                    if (vote_b) cnt_b <= cnt_b + 1;
                    if (vote_c) cnt_c <= cnt_c + 1;
                end else dly <= dly + 2'd1;
            end
        end else begin
            busy <= 1'b0; dly <= '0;
        end
    end

    typedef struct {int idx; bit acc; int lat; logic [2:0] votes; logic [3:0] id;} exp_t;
    exp_t q[$];
    int total = 0, passed = 0, ack_cnt = 0, e_acc = 0, e_rej = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        booth_req &= ~booth_ack;
    endtask

    task automatic set_booth(input int i, input logic [3:0] id, input logic [1:0] ch);
        booth_voter_id[4*i +: 4] = id;
        booth_choice[2*i +: 2]   = ch;
        booth_req[i]             = 1'b1;
    endtask

    task automatic submit(input int i, input logic [3:0] id, input logic [1:0] ch,
                          input bit acc, input int lat, input logic [2:0] votes);
        exp_t e;
        e.idx = i; e.acc = acc; e.lat = lat; e.votes = votes; e.id = id;
        q.push_back(e);
        set_booth(i, id, ch);
    endtask

    task automatic wait_acks(input int n);
        for (int i = 0; i < 300 && ack_cnt < n; i++) tick();
        if (ack_cnt < n) check("ack_wait", ack_cnt, n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bit         in_tx = 0;
        int         t0 = 0;
        logic [2:0] seen = '0;
        logic [3:0] sid = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_tx = 0; e_acc = 0; e_rej = 0;
            end else begin
                if (grant_valid && !in_tx) begin
                    in_tx = 1; t0 = cyc; seen = '0; sid = '0;
                end
                if (in_tx && (vote_a || vote_b || vote_c)) begin
                    seen |= {vote_a, vote_b, vote_c};
                    sid = voter_id;
                end
                if (booth_ack != '0) begin
                    ack_cnt++;
                    if (q.size() == 0) check("unexpected_ack", booth_ack, 0);
                    else begin
                        e = q.pop_front();
                        check("ack_idx", booth_ack, 32'(1) << e.idx);
                        check("accepted", booth_accepted, e.acc);
                        check("latency", cyc - t0 + 1, e.lat);
                        check("votes_seen", seen, e.votes);
                        if (e.votes != 0) check("voter_id", sid, e.id);
                        if (e.acc) e_acc++; else e_rej++;
                    end
                    in_tx = 0;
                end
            end
        end
    end

    initial begin
        bit gsn;
        bit hit;
        tick();
        tick();
        check("rst_ack", booth_ack, 0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_votes", {vote_a, vote_b, vote_c}, 0);
        check("rst_voter_id", voter_id, 0);
        reset = 1'b0;
        tick();

        submit(0, 4'd3, 2'b01, 1, 6, 3'b100);
        wait_acks(1);
        check("count_a_single", cnt_a, 1);

        do_reset();
        submit(0, 4'd4, 2'b01, 1, 6, 3'b100);
        submit(1, 4'd5, 2'b10, 1, 6, 3'b010);
        submit(2, 4'd6, 2'b11, 1, 6, 3'b001);
        submit(3, 4'd7, 2'b01, 1, 6, 3'b100);
        wait_acks(5);
        check("count_a", cnt_a, 2);
        check("count_b", cnt_b, 1);
        check("count_c", cnt_c, 1);

        submit(1, 4'd6, 2'b10, 0, 11, 3'b010);
        wait_acks(6);
        check("dup_count_b", cnt_b, 1);
        check("dup_count_c", cnt_c, 1);

        submit(2, 4'd9, 2'b00, 0, 2, 3'b000);
        wait_acks(7);

        voting_enabled = 1'b0;
        submit(3, 4'd8, 2'b11, 1, 6, 3'b001);
        gsn = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            gsn |= grant_valid;
        end
        check("disabled_grant", gsn, 0);
        check("disabled_acks", ack_cnt, 7);
        voting_enabled = 1'b1;
        wait_acks(8);

        submit(1, 4'd10, 2'b01, 1, 6, 3'b100);
        wait_acks(9);
`ifdef VOTE_ARB_STATS_EN
        check("stat_accepted", accepted_count, e_acc);
        check("stat_rejected", rejected_count, e_rej);
`endif

        set_booth(2, 4'd11, 2'b10);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            tick();
            hit = vote_b;
        end
        check("present_reached", hit, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_votes", {vote_a, vote_b, vote_c}, 0);
        check("mid_rst_grant_valid", grant_valid, 0);
        check("mid_rst_ack", booth_ack, 0);
`ifdef VOTE_ARB_STATS_EN
        check("mid_rst_stat_acc", accepted_count, 0);
        check("mid_rst_stat_rej", rejected_count, 0);
`endif
        booth_req = '0;
        tick();
        reset = 1'b0;
        submit(0, 4'd12, 2'b01, 1, 6, 3'b100);
        submit(3, 4'd13, 2'b11, 1, 6, 3'b001);
        wait_acks(11);
        repeat (10) tick();
        check("queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
